timer_multi: RTL and testbench



---
 rtl/timer_multi.sv | 110 +++++++++++
 tb/tb_timer_multi.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_multi.sv
// timer_multi: 64-bit prescaled machine timer with NCMP compare channels and level interrupts
module timer_multi #(
    parameter int NCMP       = 2,
    parameter int PRESCALE_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            timer_valid,
    input  logic            timer_instr,
    input  logic [31:0]     timer_addr,
    input  logic [31:0]     timer_wdata,
    input  logic [3:0]      timer_wstrb,
    output logic [31:0]     timer_rdata,
    output logic            timer_ready,
    output logic [NCMP-1:0] timer_irpt
);
    logic                  en;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pcnt;
    logic [63:0]           mtime;
    logic [31:0]           shadow;
    logic [63:0]           cmp [NCMP];
    logic                  acc;
    logic                  wr;
    logic                  rd;
    logic [31:0]           pre32;
    logic [31:0]           pre_m;
    logic [31:0]           lo_m;
    logic [31:0]           hi_m;
    logic [31:0]           rv;
    logic                  unused_instr;

    assign unused_instr = timer_instr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // Request decode, byte-merged write values and read mux over pre-edge state
    always_comb begin
        acc   = timer_valid && !timer_ready;
        wr    = acc && (timer_wstrb != 4'b0);
        rd    = acc && (timer_wstrb == 4'b0);
        pre32 = '0;
        pre32[PRESCALE_W-1:0] = prescale;
        pre_m = merge(pre32, timer_wdata, timer_wstrb);
        lo_m  = merge(mtime[31:0], timer_wdata, timer_wstrb);
        hi_m  = merge(mtime[63:32], timer_wdata, timer_wstrb);
        rv    = '0;
        if (timer_addr == 32'h0) rv = {31'b0, en};
        if (timer_addr == 32'h4) rv = pre32;
        if (timer_addr == 32'h8) rv = mtime[31:0];
        if (timer_addr == 32'hC) rv = shadow;
        for (int i = 0; i < NCMP; i++) begin
            if (timer_addr == 32'h20 + 32'(8 * i)) rv = cmp[i][31:0];
            if (timer_addr == 32'h24 + 32'(8 * i)) rv = cmp[i][63:32];
        end
    end

    // Handshake, prescaled counter (bus writes override the increment), compares and interrupts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en          <= 1'b0;
            prescale    <= '0;
            pcnt        <= '0;
            mtime       <= '0;
            shadow      <= '0;
            for (int i = 0; i < NCMP; i++) cmp[i] <= '1;
            timer_rdata <= '0;
            timer_ready <= 1'b0;
            timer_irpt  <= '0;
        end else begin
            timer_ready <= acc;
            if (rd) begin
                timer_rdata <= rv;
                if (timer_addr == 32'h8) shadow <= mtime[63:32];
            end
            if (en) begin
                pcnt <= (pcnt == prescale) ? '0 : pcnt + 1'b1;
                if (pcnt == prescale) mtime <= mtime + 64'd1;
            end
            if (wr) begin
                if (timer_addr == 32'h0 && timer_wstrb[0]) en <= timer_wdata[0];
                if (timer_addr == 32'h4) begin
                    prescale <= pre_m[PRESCALE_W-1:0];
                    pcnt     <= '0;
                end
                if (timer_addr == 32'h8) begin
                    mtime <= {mtime[63:32], lo_m};
                    pcnt  <= '0;
                end
                if (timer_addr == 32'hC) begin
                    mtime <= {hi_m, mtime[31:0]};
                    pcnt  <= '0;
                end
                for (int i = 0; i < NCMP; i++) begin
                    if (timer_addr == 32'h20 + 32'(8 * i))
                        cmp[i][31:0] <= merge(cmp[i][31:0], timer_wdata, timer_wstrb);
                    if (timer_addr == 32'h24 + 32'(8 * i))
                        cmp[i][63:32] <= merge(cmp[i][63:32], timer_wdata, timer_wstrb);
                end
            end
            for (int i = 0; i < NCMP; i++) timer_irpt[i] <= en && (mtime >= cmp[i]);
        end
    end
endmodule

// File: tb/tb_timer_multi.sv
// tb_timer_multi: randomized self-checking bench for timer_multi against an elapsed-tick model
module tb_timer_multi;
    localparam int NCMP = 2;
    localparam int PW   = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            timer_valid = 1'b0;
    logic            timer_instr = 1'b0;
    logic [31:0]     timer_addr  = '0;
    logic [31:0]     timer_wdata = '0;
    logic [3:0]      timer_wstrb = '0;
    logic [31:0]     timer_rdata;
    logic            timer_ready;
    logic [NCMP-1:0] timer_irpt;

    int errors = 0;
    int checks = 0;

    // mtime is modelled as base + floor(enabled_ticks / (prescale+1)) since the last counter/prescale write
    logic [63:0]     m_base;
    longint unsigned m_ticks;
    logic [31:0]     m_pre;
    bit              m_en;
    logic [31:0]     m_shadow;
    logic [63:0]     m_cmp [NCMP];
    bit              m_rdy;
    logic [31:0]     m_rd;
    logic [NCMP-1:0] m_irq;

    timer_multi #(.NCMP(NCMP), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .timer_valid(timer_valid), .timer_instr(timer_instr),
        .timer_addr(timer_addr), .timer_wdata(timer_wdata), .timer_wstrb(timer_wstrb),
        .timer_rdata(timer_rdata), .timer_ready(timer_ready), .timer_irpt(timer_irpt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] m_time();
        return m_base + 64'(m_ticks / (64'(m_pre) + 64'd1));
    endfunction

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] w, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [63:0] t);
        logic [31:0] r;
        r = '0;
        if (a == 32'h0) r = {31'b0, m_en};
        if (a == 32'h4) r = m_pre;
        if (a == 32'h8) r = t[31:0];
        if (a == 32'hC) r = m_shadow;
        for (int i = 0; i < NCMP; i++) begin
            if (a == 32'h20 + 32'(8 * i)) r = m_cmp[i][31:0];
            if (a == 32'h24 + 32'(8 * i)) r = m_cmp[i][63:32];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_base = '0; m_ticks = 0; m_pre = '0; m_en = 0; m_shadow = '0;
        for (int i = 0; i < NCMP; i++) m_cmp[i] = '1;
        m_rdy = 0; m_rd = '0; m_irq = '0;
    endtask

    // One clock edge: drive the bus, advance the model, land 1 time unit after the edge
    task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        logic [63:0]     t0;
        logic [NCMP-1:0] nirq;
        bit              acc;
        timer_valid = v; timer_addr = a; timer_wdata = w; timer_wstrb = s;
        t0  = m_time();
        acc = v && !m_rdy;
        for (int i = 0; i < NCMP; i++) nirq[i] = m_en && (t0 >= m_cmp[i]);
        if (acc && s == 4'b0) begin
            m_rd = m_read(a, t0);
            if (a == 32'h8) m_shadow = t0[63:32];
        end
        @(posedge clk);
        if (m_en) m_ticks++;
        if (acc && s != 4'b0) begin
            if (a == 32'h0 && s[0]) m_en = w[0];
            if (a == 32'h4) begin
                m_base = m_time(); m_ticks = 0;
                m_pre = mrg(m_pre, w, s) & 32'((64'd1 << PW) - 1);
            end
            if (a == 32'h8) begin m_base = {t0[63:32], mrg(t0[31:0], w, s)}; m_ticks = 0; end
            if (a == 32'hC) begin m_base = {mrg(t0[63:32], w, s), t0[31:0]}; m_ticks = 0; end
            for (int i = 0; i < NCMP; i++) begin
                if (a == 32'h20 + 32'(8 * i)) m_cmp[i][31:0] = mrg(m_cmp[i][31:0], w, s);
                if (a == 32'h24 + 32'(8 * i)) m_cmp[i][63:32] = mrg(m_cmp[i][63:32], w, s);
            end
        end
        m_rdy = acc;
        m_irq = nirq;
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, '0, '0, '0);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1, a, '0, '0);
        cyc(0, '0, '0, '0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        cyc(1, a, d, s);
        cyc(0, '0, '0, '0);
    endtask

    task automatic do_reset();
        timer_valid = 0;
        rst = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] regs [4];
        regs = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset();
        checks++; if (timer_ready !== 1'b0 || timer_irpt !== '0 || timer_rdata !== '0) begin
            errors++; $display("FAIL reset_outputs ready=%b irpt=%b rdata=%h exp 0", timer_ready, timer_irpt, timer_rdata);
        end
        cyc(1, 32'h4, '0, '0);
        checks++; if (timer_ready !== 1'b1) begin errors++; $display("FAIL ready_after_valid got %b exp 1", timer_ready); end
        cyc(0, '0, '0, '0);
        checks++; if (timer_ready !== 1'b0) begin errors++; $display("FAIL ready_one_cycle got %b exp 0", timer_ready); end
        foreach (regs[k]) begin
            rd(regs[k]);
            checks++; if (timer_rdata !== 32'h0) begin errors++; $display("FAIL reset_reg_%h got %h exp 0", regs[k], timer_rdata); end
        end
        for (int i = 0; i < 2 * NCMP; i++) begin
            rd(32'h20 + 32'(4 * i));
            checks++; if (timer_rdata !== 32'hFFFF_FFFF) begin
                errors++; $display("FAIL reset_cmp_%0d got %h exp ffffffff", i, timer_rdata);
            end
        end
        checks++; if (timer_irpt !== '0) begin errors++; $display("FAIL reset_irpt got %b exp 0", timer_irpt); end
    endtask

    task automatic test_prescale();
        idle(5);
        rd(32'h8);
        checks++; if (timer_rdata !== 32'h0) begin errors++; $display("FAIL frozen_at_zero got %h exp 0", timer_rdata); end
        wr(32'h4, 32'd3, 4'hF);
        wr(32'h0, 32'd1, 4'h1);
        idle(40);
        wr(32'h0, 32'd0, 4'h1);
        rd(32'h8);
        checks++; if (timer_rdata !== m_rd) begin errors++; $display("FAIL prescale3_lo got %h exp %h", timer_rdata, m_rd); end
        idle(10);
        rd(32'h8);
        checks++; if (timer_rdata !== m_rd) begin errors++; $display("FAIL frozen_lo got %h exp %h", timer_rdata, m_rd); end
        for (int k = 0; k < 4; k++) begin
            wr(32'h4, $urandom_range(0, 5), 4'hF);
            wr(32'h0, 32'd1, 4'h1);
            idle($urandom_range(3, 60));
            wr(32'h0, 32'd0, 4'h1);
            rd(32'h8);
            checks++; if (timer_rdata !== m_rd) begin errors++; $display("FAIL rand_prescale_%0d got %h exp %h", k, timer_rdata, m_rd); end
            rd(32'h4);
            checks++; if (timer_rdata !== m_rd) begin errors++; $display("FAIL prescale_rb_%0d got %h exp %h", k, timer_rdata, m_rd); end
        end
    endtask

    task automatic test_wrap();
        wr(32'h8, 32'hFFFF_FFFE, 4'hF);
        wr(32'hC, 32'hFFFF_FFFF, 4'hF);
        wr(32'h4, 32'h0, 4'hF);
        wr(32'h0, 32'd1, 4'h1);
        idle(2);
        rd(32'h8);
        checks++; if (timer_rdata !== 32'h1 || timer_rdata !== m_rd) begin
            errors++; $display("FAIL wrap_lo got %h exp 00000001 model %h", timer_rdata, m_rd);
        end
        rd(32'hC);
        checks++; if (timer_rdata !== 32'h0 || timer_rdata !== m_rd) begin
            errors++; $display("FAIL wrap_hi got %h exp 00000000 model %h", timer_rdata, m_rd);
        end
    endtask

    task automatic test_shadow();
        wr(32'h4, 32'd3, 4'hF);
        wr(32'hC, 32'h0, 4'hF);
        wr(32'h8, 32'hFFFF_FFFF, 4'hF);
        rd(32'h8);
        checks++; if (timer_rdata !== 32'hFFFF_FFFF || timer_rdata !== m_rd) begin
            errors++; $display("FAIL shadow_lo got %h exp ffffffff model %h", timer_rdata, m_rd);
        end
        rd(32'hC);
        checks++; if (timer_rdata !== 32'h0 || timer_rdata !== m_rd) begin
            errors++; $display("FAIL shadow_hi got %h exp 00000000 model %h", timer_rdata, m_rd);
        end
        rd(32'h8);
        rd(32'hC);
        checks++; if (timer_rdata !== 32'h1 || timer_rdata !== m_rd) begin
            errors++; $display("FAIL carried_hi got %h exp 00000001 model %h", timer_rdata, m_rd);
        end
    endtask

    task automatic test_irpt();
        wr(32'h0, 32'd0, 4'h1);
        wr(32'h4, 32'd0, 4'hF);
        wr(32'h8, 32'd0, 4'hF);
        wr(32'hC, 32'd0, 4'hF);
        wr(32'h20, 32'd20, 4'hF);
        wr(32'h24, 32'd0, 4'hF);
        wr(32'h28, 32'd40, 4'hF);
        wr(32'h2C, 32'd0, 4'hF);
        wr(32'h0, 32'd1, 4'h1);
        for (int k = 0; k < 50; k++) begin
            cyc(0, '0, '0, '0);
            checks++; if (timer_irpt !== m_irq) begin errors++; $display("FAIL irpt_run_%0d got %b exp %b", k, timer_irpt, m_irq); end
        end
        checks++; if (timer_irpt !== 2'b11) begin errors++; $display("FAIL irpt_both got %b exp 11", timer_irpt); end
        cyc(1, 32'h20, 32'd100, 4'hF);
        checks++; if (timer_irpt !== 2'b11) begin errors++; $display("FAIL irpt_lag got %b exp 11", timer_irpt); end
        for (int k = 0; k < 4; k++) begin
            cyc(0, '0, '0, '0);
            checks++; if (timer_irpt !== m_irq) begin errors++; $display("FAIL irpt_raise_%0d got %b exp %b", k, timer_irpt, m_irq); end
        end
        checks++; if (timer_irpt !== 2'b10) begin errors++; $display("FAIL irpt_cleared got %b exp 10", timer_irpt); end
        wr(32'h0, 32'd0, 4'h1);
        idle(2);
        checks++; if (timer_irpt !== 2'b00) begin errors++; $display("FAIL irpt_en_off got %b exp 00", timer_irpt); end
    endtask

    task automatic test_strobe();
        wr(32'h28, 32'h1234_5678, 4'hF);
        wr(32'h28, 32'h00AB_0000, 4'b0100);
        rd(32'h28);
        checks++; if (timer_rdata !== 32'h12AB_5678) begin errors++; $display("FAIL strobe_byte2 got %h exp 12ab5678", timer_rdata); end
        cyc(1, 32'h18, 32'hFFFF_FFFF, 4'hF);
        checks++; if (timer_ready !== 1'b1) begin errors++; $display("FAIL hole_write_ack got %b exp 1", timer_ready); end
        cyc(0, '0, '0, '0);
        rd(32'h18);
        checks++; if (timer_rdata !== 32'h0) begin errors++; $display("FAIL hole_read got %h exp 0", timer_rdata); end
        rd(32'h30);
        checks++; if (timer_rdata !== 32'h0) begin errors++; $display("FAIL past_cmp_read got %h exp 0", timer_rdata); end
        foreach (m_cmp[i]) begin
            rd(32'h20 + 32'(8 * i));
            checks++; if (timer_rdata !== m_rd) begin errors++; $display("FAIL hole_cmp_%0d got %h exp %h", i, timer_rdata, m_rd); end
        end
        rd(32'h4);
        checks++; if (timer_rdata !== m_rd) begin errors++; $display("FAIL hole_prescale got %h exp %h", timer_rdata, m_rd); end
    endtask

    task automatic test_back_to_back();
        bit exp_r [4];
        exp_r = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            cyc(1, 32'h4, '0, '0);
            checks++; if (timer_ready !== exp_r[k]) begin errors++; $display("FAIL held_ready_%0d got %b exp %b", k, timer_ready, exp_r[k]); end
        end
        cyc(0, '0, '0, '0);
    endtask

    task automatic test_random();
        logic [31:0] al [11];
        logic [31:0] a;
        al = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h20, 32'h24, 32'h28, 32'h2C, 32'h18, 32'h30, 32'h14};
        for (int k = 0; k < 150; k++) begin
            a = al[$urandom_range(0, 10)];
            if ($urandom_range(0, 1) == 1) begin
                if (a == 32'h4) wr(a, $urandom_range(0, 3), 4'($urandom_range(1, 15)));
                else if (a == 32'h0) wr(a, 32'($urandom_range(0, 3) != 0), 4'h1);
                else wr(a, $urandom, 4'($urandom_range(1, 15)));
            end else begin
                rd(a);
                checks++; if (timer_rdata !== m_rd) begin errors++; $display("FAIL rand_rd_%0d_%h got %h exp %h", k, a, timer_rdata, m_rd); end
            end
            cyc(0, '0, '0, '0);
            checks++; if (timer_irpt !== m_irq) begin errors++; $display("FAIL rand_irpt_%0d got %b exp %b", k, timer_irpt, m_irq); end
        end
    endtask

    task automatic test_reset_mid();
        wr(32'h20, 32'h0, 4'hF);
        wr(32'h24, 32'h0, 4'hF);
        wr(32'h0, 32'd1, 4'h1);
        idle(2);
        checks++; if (timer_irpt[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_irpt got %b exp 1", timer_irpt[0]); end
        cyc(1, 32'h0, '0, '0);
        #2 rst = 0;
        #1;
        checks++; if (timer_ready !== 1'b0 || timer_irpt !== '0 || timer_rdata !== '0) begin
            errors++; $display("FAIL async_reset ready=%b irpt=%b rdata=%h exp 0", timer_ready, timer_irpt, timer_rdata);
        end
        timer_valid = 0;
        @(negedge clk);
        rst = 1;
        model_reset();
        rd(32'h20);
        checks++; if (timer_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp_after_reset got %h exp ffffffff", timer_rdata); end
        rd(32'h0);
        checks++; if (timer_rdata !== 32'h0) begin errors++; $display("FAIL ctrl_after_reset got %h exp 0", timer_rdata); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_prescale();
        test_wrap();
        test_shadow();
        test_irpt();
        test_strobe();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
